// File: rtl/ecc_encoding_pipe.sv
// Write-path SECDED encoder: pairs 20-bit RAM lanes into 32-bit words per SRAM mode,
// appends Hamming check bits, two-stage valid/ready pipe. Optional: ECC_ERR_INJECT_EN.
module ecc_encoding_pipe #(
    parameter logic [2:0] CONFIG_TDP_NONSPLIT = 3'd0,
    parameter logic [2:0] CONFIG_TDP_SPLIT    = 3'd1,
    parameter logic [2:0] CONFIG_SDP_NONSPLIT = 3'd2,
    parameter logic [2:0] CONFIG_SDP_SPLIT    = 3'd3,
    parameter logic [2:0] CONFIG_CASCADE_LOW  = 3'd4,
    parameter logic [2:0] CONFIG_CASCADE_UP   = 3'd5,
    parameter logic [2:0] CONFIG_FIFO_SYNC    = 3'd6,
    parameter logic [2:0] CONFIG_FIFO_ASYNC   = 3'd7
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  cfg_sram_mode_i,
    input  logic [1:0]  cfg_ecc_enable_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [19:0] a0_data_i,
    input  logic [19:0] a1_data_i,
    input  logic [19:0] b0_data_i,
    input  logic [19:0] b1_data_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [19:0] a0_data_o,
    output logic [19:0] a1_data_o,
    output logic [19:0] b0_data_o,
    output logic [19:0] b1_data_o
`ifdef ECC_ERR_INJECT_EN
    ,
    input  logic        inj_arm_i,
    input  logic [39:0] inj_mask_i,
    output logic [7:0]  inj_count_o
`endif
);

    // Hamming positions 1..38, check bits at powers of two, chk[6] overall parity.
    function automatic logic [7:0] secded_chk(input logic [31:0] d);
        logic [7:0]  c;
        logic [5:0]  k;
        logic [5:0]  p;
        c = '0;
        k = '0;
        for (int unsigned pos = 3; pos <= 38; pos++) begin
            p = pos[5:0];
            if ((p & (p - 6'd1)) != 6'd0) begin
                for (int unsigned i = 0; i < 6; i++) begin
                    if (p[i]) c[i] = c[i] ^ d[k[4:0]];
                end
                k = k + 6'd1;
            end
        end
        c[6] = (^d) ^ (^c[5:0]);
        return c;
    endfunction

    logic        s1_v_q, s1_v_d;
    logic [2:0]  s1_mode_q, s1_mode_d;
    logic [1:0]  s1_en_q, s1_en_d;
    logic [19:0] s1_a0_q, s1_a0_d, s1_a1_q, s1_a1_d;
    logic [19:0] s1_b0_q, s1_b0_d, s1_b1_q, s1_b1_d;

    logic        s2_v_q, s2_v_d;
    logic [19:0] s2_a0_q, s2_a0_d, s2_a1_q, s2_a1_d;
    logic [19:0] s2_b0_q, s2_b0_d, s2_b1_q, s2_b1_d;

    logic        accept, s2_adv, s2_load;
    logic        nonsplit, split;
    logic [7:0]  chk_a, chk_b, chk_0, chk_1;
    logic [19:0] enc_a0, enc_a1, enc_b0, enc_b1;

`ifdef ECC_ERR_INJECT_EN
    logic        inj_armed_q, inj_armed_d;
    logic [39:0] inj_mask_q, inj_mask_d;
    logic [7:0]  inj_count_q, inj_count_d;
    logic        inj_hit;
`endif

    assign ready_o = !s1_v_q || !s2_v_q || ready_i;
    assign accept  = valid_i && ready_o;
    assign s2_adv  = !s2_v_q || ready_i;
    assign s2_load = s1_v_q && s2_adv;

    always_comb begin
        nonsplit = 1'b0;
        split    = 1'b0;
        case (s1_mode_q)
            CONFIG_TDP_NONSPLIT, CONFIG_SDP_NONSPLIT: nonsplit = s1_en_q[0];
            CONFIG_SDP_SPLIT:                         split    = 1'b1;
            CONFIG_TDP_SPLIT, CONFIG_CASCADE_LOW, CONFIG_CASCADE_UP,
            CONFIG_FIFO_SYNC, CONFIG_FIFO_ASYNC:      split    = 1'b0;
            default:                                  split    = 1'b0;
        endcase

        chk_a = secded_chk({s1_a1_q[15:0], s1_a0_q[15:0]});
        chk_b = secded_chk({s1_b1_q[15:0], s1_b0_q[15:0]});
        chk_0 = secded_chk({s1_b0_q[15:0], s1_a0_q[15:0]});
        chk_1 = secded_chk({s1_b1_q[15:0], s1_a1_q[15:0]});

        enc_a0 = s1_a0_q;
        enc_a1 = s1_a1_q;
        enc_b0 = s1_b0_q;
        enc_b1 = s1_b1_q;
        if (nonsplit) begin
            enc_a0 = {chk_a[3:0], s1_a0_q[15:0]};
            enc_a1 = {chk_a[7:4], s1_a1_q[15:0]};
            enc_b0 = {chk_b[3:0], s1_b0_q[15:0]};
            enc_b1 = {chk_b[7:4], s1_b1_q[15:0]};
        end else begin
            if (s1_en_q[0]) begin
                enc_a0 = {chk_0[3:0], s1_a0_q[15:0]};
                enc_b0 = {chk_0[7:4], s1_b0_q[15:0]};
            end
            if (split && s1_en_q[1]) begin
                enc_a1 = {chk_1[3:0], s1_a1_q[15:0]};
                enc_b1 = {chk_1[7:4], s1_b1_q[15:0]};
            end
        end

`ifdef ECC_ERR_INJECT_EN
        // Mask is applied as the word enters S2 so a stalled output never changes.
        inj_hit     = s2_load && inj_armed_q;
        inj_armed_d = inj_armed_q;
        inj_mask_d  = inj_mask_q;
        inj_count_d = inj_count_q;
        if (inj_hit) begin
            enc_a0 = enc_a0 ^ inj_mask_q[19:0];
            if (nonsplit) enc_a1 = enc_a1 ^ inj_mask_q[39:20];
            else          enc_b0 = enc_b0 ^ inj_mask_q[39:20];
            inj_armed_d = 1'b0;
            if (inj_count_q != 8'hFF) inj_count_d = inj_count_q + 8'd1;
        end
        if (inj_arm_i) begin
            inj_armed_d = 1'b1;
            inj_mask_d  = inj_mask_i;
        end
`endif

        s1_v_d    = s1_v_q;
        s1_mode_d = s1_mode_q;
        s1_en_d   = s1_en_q;
        s1_a0_d   = s1_a0_q;
        s1_a1_d   = s1_a1_q;
        s1_b0_d   = s1_b0_q;
        s1_b1_d   = s1_b1_q;
        if (accept) begin
            s1_v_d    = 1'b1;
            s1_mode_d = cfg_sram_mode_i;
            s1_en_d   = cfg_ecc_enable_i;
            s1_a0_d   = a0_data_i;
            s1_a1_d   = a1_data_i;
            s1_b0_d   = b0_data_i;
            s1_b1_d   = b1_data_i;
        end else if (s2_adv) begin
            s1_v_d = 1'b0;
        end

        s2_v_d  = s2_v_q;
        s2_a0_d = s2_a0_q;
        s2_a1_d = s2_a1_q;
        s2_b0_d = s2_b0_q;
        s2_b1_d = s2_b1_q;
        if (s2_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_a0_d = enc_a0;
                s2_a1_d = enc_a1;
                s2_b0_d = enc_b0;
                s2_b1_d = enc_b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_v_q    <= 1'b0;
            s1_mode_q <= '0;
            s1_en_q   <= '0;
            s1_a0_q   <= '0;
            s1_a1_q   <= '0;
            s1_b0_q   <= '0;
            s1_b1_q   <= '0;
            s2_v_q    <= 1'b0;
            s2_a0_q   <= '0;
            s2_a1_q   <= '0;
            s2_b0_q   <= '0;
            s2_b1_q   <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_mode_q <= s1_mode_d;
            s1_en_q   <= s1_en_d;
            s1_a0_q   <= s1_a0_d;
            s1_a1_q   <= s1_a1_d;
            s1_b0_q   <= s1_b0_d;
            s1_b1_q   <= s1_b1_d;
            s2_v_q    <= s2_v_d;
            s2_a0_q   <= s2_a0_d;
            s2_a1_q   <= s2_a1_d;
            s2_b0_q   <= s2_b0_d;
            s2_b1_q   <= s2_b1_d;
        end
    end

`ifdef ECC_ERR_INJECT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inj_armed_q <= 1'b0;
            inj_mask_q  <= '0;
            inj_count_q <= '0;
        end else begin
            inj_armed_q <= inj_armed_d;
            inj_mask_q  <= inj_mask_d;
            inj_count_q <= inj_count_d;
        end
    end

    assign inj_count_o = inj_count_q;
`endif

    assign valid_o   = s2_v_q;
    assign a0_data_o = s2_a0_q;
    assign a1_data_o = s2_a1_q;
    assign b0_data_o = s2_b0_q;
    assign b1_data_o = s2_b1_q;

endmodule
